// File: rtl/level_driver_pkg.sv
// Shared dwell-timing types and helpers for the level driver / debouncer family.
package level_driver_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    HOLD   = 1'b1
  } dwell_state_e;

  // Counter width for a modulo-n count, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 32'($clog2(n));
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/level_driver_dwell_timer.sv
// clk_en-gated up-counter that clears itself on reaching Limit-1.
module dwell_timer
  import level_driver_pkg::*;
#(
  parameter int unsigned Limit = 4
) (
  input  logic clk,
  input  logic sync_rst,
  input  logic clk_en,
  input  logic clear,
  input  logic run,
  output logic terminal_c
);

  localparam int unsigned CntW = cnt_width(Limit);

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  assign terminal_c = (count_q == CntW'(Limit - 32'd1));

  // The terminal compare clears the count, so it never wraps.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = terminal_c ? '0 : count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      count_q <= '0;
    end else if (clk_en) begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/level_driver.sv
// Drives an output pin from an internal level request, enforcing a minimum
// dwell time between pin transitions.
module level_driver
  import level_driver_pkg::*;
#(
  parameter int unsigned Min_Hold_Cycles = 3_500_000,
  parameter logic        Idle_Level      = 1'b0,
  parameter logic        Output_Invert   = 1'b0
) (
  input  logic clk,
  input  logic sync_rst,
  input  logic clk_en,
  input  logic level_request,
  output logic io_out,
  output logic level_applied,
  output logic busy,
  output logic pending
);

  dwell_state_e state_q;
  dwell_state_e state_d;
  logic         buf_q;
  logic         buf_d;
  logic         applied_q;
  logic         applied_d;
  logic         out_q;
  logic         out_d;
  logic         timer_clear;
  logic         timer_run;
  logic         timer_done_c;

  dwell_timer #(
    .Limit (Min_Hold_Cycles)
  ) u_dwell_timer (
    .clk        (clk),
    .sync_rst   (sync_rst),
    .clk_en     (clk_en),
    .clear      (timer_clear),
    .run        (timer_run),
    .terminal_c (timer_done_c)
  );

  // A buffered request is only committed from STABLE; changes during HOLD wait.
  always_comb begin
    state_d     = state_q;
    applied_d   = applied_q;
    buf_d       = level_request;
    out_d       = applied_q ^ Output_Invert;
    timer_clear = 1'b0;
    timer_run   = 1'b0;
    case (state_q)
      STABLE: begin
        if (buf_q != applied_q) begin
          applied_d   = buf_q;
          state_d     = HOLD;
          timer_clear = 1'b1;
        end
      end
      HOLD: begin
        timer_run = 1'b1;
        if (timer_done_c) begin
          state_d = STABLE;
        end
      end
      default: begin
        state_d     = STABLE;
        timer_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q   <= STABLE;
      buf_q     <= Idle_Level;
      applied_q <= Idle_Level;
      out_q     <= Idle_Level ^ Output_Invert;
    end else if (clk_en) begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      applied_q <= applied_d;
      out_q     <= out_d;
    end
  end

  assign io_out        = out_q;
  assign level_applied = applied_q;
  assign busy          = (state_q == HOLD);
  assign pending       = (buf_q != applied_q);

endmodule

// File: tb/tb_level_driver.sv
// Directed-vector bench for level_driver: one table row per clock edge.
module tb_level_driver;

  logic clk;
  logic sync_rst;
  logic clk_en;
  logic level_request;
  logic io_out;
  logic level_applied;
  logic busy;
  logic pending;

  int checks   = 0;
  int failures = 0;

  level_driver #(
    .Min_Hold_Cycles (4),
    .Idle_Level      (1'b0),
    .Output_Invert   (1'b1)
  ) dut (
    .clk           (clk),
    .sync_rst      (sync_rst),
    .clk_en        (clk_en),
    .level_request (level_request),
    .io_out        (io_out),
    .level_applied (level_applied),
    .busy          (busy),
    .pending       (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row = {sync_rst, clk_en, level_request, io_out, level_applied, busy, pending};
  // inputs are applied before an edge, outputs are expected after it.
  localparam int NumVec = 59;
  logic [6:0] vec_tbl [NumVec] = '{
    7'b101_1000, 7'b101_1000, 7'b010_1000,                             // reset, clk_en=0 then idle
    7'b011_1001, 7'b011_1110, 7'b011_0110, 7'b011_0110, 7'b011_0110,   // basic apply
    7'b011_0100, 7'b011_0100,
    7'b010_0101, 7'b010_0010, 7'b011_1011, 7'b010_1010, 7'b010_1010,   // glitch inside HOLD
    7'b010_1000, 7'b010_1000,
    7'b011_1001, 7'b011_1110, 7'b011_0110, 7'b011_0110, 7'b011_0110,   // change at terminal edge
    7'b010_0101, 7'b010_0010, 7'b010_1010, 7'b010_1010, 7'b010_1010,
    7'b010_1000,
    7'b011_1001, 7'b011_1110, 7'b000_1110, 7'b001_1110, 7'b011_0110,   // clk_en 1-of-3 in HOLD
    7'b001_0110, 7'b001_0110, 7'b011_0110, 7'b001_0110, 7'b001_0110,
    7'b011_0110, 7'b001_0110, 7'b001_0110, 7'b011_0100,
    7'b010_0101, 7'b010_0010, 7'b010_1010, 7'b010_1010, 7'b010_1010,   // fall back to 0
    7'b010_1000,
    7'b011_1001, 7'b011_1110, 7'b011_0110, 7'b011_0110,                // reset at HOLD count 2
    7'b101_1000,
    7'b011_1001, 7'b011_1110, 7'b011_0110, 7'b011_0110, 7'b011_0110,   // fresh apply after reset
    7'b011_0100
  };

  task automatic chk_eq(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  initial begin
    logic [6:0] row;
    sync_rst      = 1'b1;
    clk_en        = 1'b0;
    level_request = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NumVec; i++) begin
      row           = vec_tbl[i];
      sync_rst      = row[6];
      clk_en        = row[5];
      level_request = row[4];
      @(posedge clk);
      #1;
      chk_eq($sformatf("row%0d_io_out", i),        io_out,        row[3]);
      chk_eq($sformatf("row%0d_level_applied", i), level_applied, row[2]);
      chk_eq($sformatf("row%0d_busy", i),          busy,          row[1]);
      chk_eq($sformatf("row%0d_pending", i),       pending,       row[0]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
